// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module  : cache_pkg
// Brief   : Line geometry shared with the instruction cache, plus refill states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

    localparam int BLOCK_WIDTH = 4;
    localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_refill.sv
//------------------------------------------------------------------------------
// Module  : icache_refill
// Brief   : Fetches one cache line byte-by-byte over the arbitrated RAM port
//           and hands it to the instruction cache with a single-cycle pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_refill #(
    parameter  int BLOCK_WIDTH = cache_pkg::BLOCK_WIDTH,
    localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    flushIn,
    input  logic                    missIn,
    input  logic [31:BLOCK_WIDTH]   missAddrIn,
    output logic                    ramReq,
    input  logic                    ramGrant,
    output logic [31:0]             ramAddr,
    output logic                    ramReadEn,
    input  logic [7:0]              ramDataIn,
    output logic                    memDataValid,
    output logic [31:BLOCK_WIDTH]   memAddr,
    output logic [BLOCK_SIZE*8-1:0] memDataOut
);

    import cache_pkg::*;

    localparam int CW = BLOCK_WIDTH + 1;

    refill_state_e              state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [31:BLOCK_WIDTH]      addr_q, addr_d;
    logic [BLOCK_SIZE*8-1:0]    line_q, line_d;
    logic                       ram_req_q, ram_req_d;
    logic                       ram_rd_en_q, ram_rd_en_d;
    logic [31:0]                ram_addr_q, ram_addr_d;
    logic                       mem_valid_q, mem_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;

        case (state_q)
            IDLE: begin
                if (missIn && !flushIn) begin
                    addr_d  = missAddrIn;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flushIn) begin
                    state_d = IDLE;
                end else if (ramGrant) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (flushIn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // Data lags its address by one cycle, so count k lands byte k-1.
                    for (int k = 0; k < BLOCK_SIZE; k++) begin
                        if (cnt_q == CW'(k + 1)) begin
                            line_d[8*k +: 8] = ramDataIn;
                        end
                    end
                    if (cnt_q == CW'(BLOCK_SIZE)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        ram_req_d   = (state_d == REQ) || (state_d == READ);
        ram_rd_en_d = (state_d == READ) && (cnt_d < CW'(BLOCK_SIZE));
        ram_addr_d  = ram_rd_en_d ? {addr_d, cnt_d[BLOCK_WIDTH-1:0]} : 32'd0;
        mem_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            ram_req_q   <= 1'b0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            ram_req_q   <= ram_req_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_addr_q  <= ram_addr_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign ramReq       = ram_req_q;
    assign ramReadEn    = ram_rd_en_q;
    assign ramAddr      = ram_addr_q;
    assign memDataValid = mem_valid_q;
    assign memAddr      = addr_q;
    assign memDataOut   = line_q;

endmodule

`default_nettype wire

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine for the instruction cache; answers the cache's miss.
- On a miss, latches the missing line address and wins the shared byte-wide RAM port through the memory arbiter.
- Reads BLOCK_SIZE consecutive bytes, assembles them little-endian into one line, and returns it with a one-cycle valid pulse on the cache fill interface.

Parameters:
- BLOCK_WIDTH, 4, log2 of line size in bytes; must match the cache.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (derived; do not override).

Ports:
- clkIn  input  1  system clock; single clock domain.
- resetIn  input  1  reset, asynchronous, active-low.
- flushIn  input  1  pipeline flush (branch mispredict); aborts an in-flight refill.
- missIn  input  1  cache miss for the current fetch.
- missAddrIn  input  [31:BLOCK_WIDTH]  line address of the missing fetch.
- ramReq  output  1  request for the RAM port to the arbiter.
- ramGrant  input  1  arbiter grant; held by the arbiter while ramReq stays high.
- ramAddr  output  32  byte address to RAM.
- ramReadEn  output  1  read strobe; high exactly when ramAddr carries a valid read.
- ramDataIn  input  8  RAM read data, valid the cycle after its address.
- memDataValid  output  1  one-cycle fill pulse to the cache.
- memAddr  output  [31:BLOCK_WIDTH]  line address being filled.
- memDataOut  output  [BLOCK_SIZE*8-1:0]  assembled line; byte k at bits [8k+7:8k].

Behaviour:
- Reset (resetIn low, asynchronous): state IDLE, counter 0, line register 0, latched address 0, all outputs 0.
- States: IDLE, REQ, READ, DONE. All transitions occur on the rising edge of clkIn.
- IDLE:
  - ramReq=0, memDataValid=0.
  - If missIn=1 and flushIn=0: latch missAddrIn, go to REQ.
- REQ:
  - ramReq=1.
  - flushIn=1 -> IDLE.
  - Else if ramGrant=1 -> READ with cnt=0.
  - Else stay in REQ.
- READ: ramReq=1; cnt runs 0..BLOCK_SIZE (BLOCK_WIDTH+1 bits).
  - While cnt<BLOCK_SIZE: ramAddr={latched addr, cnt[BLOCK_WIDTH-1:0]}, ramReadEn=1.
  - At cnt=BLOCK_SIZE: ramAddr=0, ramReadEn=0.
  - At each edge with cnt>=1: ramDataIn is written into byte cnt-1 of the line register.
  - At the edge with cnt=BLOCK_SIZE: go to DONE.
  - flushIn=1 at any READ edge -> IDLE immediately; no pulse, partial line discarded.
- DONE:
  - memDataValid=1 for exactly this cycle; memAddr=latched addr; memDataOut=line register; ramReq=0.
  - Next state is IDLE unconditionally.
  - flushIn does not suppress the pulse: the line is correct for its address.
- memAddr and memDataOut are held stable outside DONE as well; consumers qualify them with memDataValid only.
- Latency (grant available immediately):
  - missIn seen in IDLE at cycle 0 -> REQ at cycle 1 -> READ at cycles 2..18 -> DONE at cycle 19.
  - Total is BLOCK_SIZE+3 cycles.
  - Each cycle of grant delay adds one cycle.
- Boundary conditions:
  - missIn is ignored outside IDLE; missAddrIn changes during a refill have no effect.
  - flushIn and missIn high together in IDLE: flush wins, stay in IDLE.
  - The cache updates on the DONE pulse, so missIn is low in the following IDLE cycle. A still-high missIn there (new address) starts a new refill normally.
  - ramGrant is sampled only in REQ. Grant dropping in READ is an arbiter protocol violation, covered by a bench assertion; RTL behaviour is undefined.
  - Line address at the top of memory: the byte index does not carry into the line address; the read never crosses the line boundary.
  - Reset asserted mid-READ: immediate return to the reset values; ramReq drops asynchronously.

Decomposition:
- Shared package (cache_pkg): BLOCK_WIDTH/BLOCK_SIZE constants shared with the instruction cache, plus the refill state enum (IDLE, REQ, READ, DONE).
- No sub-module: one state register, one counter, one byte-write line register. Keep it flat.

Test Plan:
- Basic refill:
  - Stimulus: missIn=1, missAddrIn=0x0000100 (byte 0x1000), grant tied high, RAM byte at addr A = A[7:0].
  - Required: memDataValid pulses exactly at cycle 19; memAddr=0x0000100; memDataOut=0x0F0E0D0C_0B0A0908_07060504_03020100.
  - Required: ramAddr sequence 0x1000..0x100F with ramReadEn high for 16 cycles.
- Grant delay:
  - Stimulus: grant withheld for 5 cycles in REQ.
  - Required: ramReq stays high throughout; pulse arrives at cycle 24; data identical to the basic refill.
- Flush mid-READ:
  - Stimulus: flushIn pulsed at cnt=7.
  - Required: next cycle state IDLE, ramReq=0, ramReadEn=0; no memDataValid pulse within 30 cycles.
  - Required: a new miss at 0x2000 then fills correctly with bytes 0x00..0x0F.
- Flush in DONE and flush+miss in IDLE:
  - Required: flush in DONE still yields the pulse.
  - Required: simultaneous flushIn=1, missIn=1 in IDLE gives ramReq=0 on the next cycle.
- Async reset mid-READ:
  - Stimulus: resetIn driven low between clock edges at cnt=9.
  - Required: ramReq, memDataValid and memDataOut read 0 before the next edge.
  - Required: after release, a miss at 0xFFFFFFF0 produces ramAddr 0xFFFFFFF0..0xFFFFFFFF, with no wrap into the line address.
